// File: rtl/cmos_geom_pkg.sv
// Shared types and the panel-ID geometry table for cmos_geom_ctrl.
//   geom_t       : {h, v, hts, vts, y_st, y_end}, each GEOM_W bits
//   ID_xxxx      : known LCD panel IDs (the hex ID codes read back from the panel)
//   geom_lookup  : panel ID -> camera geometry, default entry for unknown IDs
//   state_t      : controller FSM states
package cmos_geom_pkg;

  localparam int GEOM_W   = 16;
  localparam int LUT_ID_W = 16;

  typedef struct packed {
    logic [GEOM_W-1:0] h;
    logic [GEOM_W-1:0] v;
    logic [GEOM_W-1:0] hts;
    logic [GEOM_W-1:0] vts;
    logic [GEOM_W-1:0] y_st;
    logic [GEOM_W-1:0] y_end;
  } geom_t;

  localparam logic [LUT_ID_W-1:0] ID_4342 = 16'h4342;
  localparam logic [LUT_ID_W-1:0] ID_7084 = 16'h7084;
  localparam logic [LUT_ID_W-1:0] ID_4384 = 16'h4384;
  localparam logic [LUT_ID_W-1:0] ID_7016 = 16'h7016;
  localparam logic [LUT_ID_W-1:0] ID_1018 = 16'h1018;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_LOOKUP,
    ST_MULT,
    ST_REQ,
    ST_DONE
  } state_t;

  function automatic geom_t mk_geom(input int h, input int v, input int hts,
                                    input int vts, input int y_st, input int y_end);
    geom_t g;
    g.h     = GEOM_W'(h);
    g.v     = GEOM_W'(v);
    g.hts   = GEOM_W'(hts);
    g.vts   = GEOM_W'(vts);
    g.y_st  = GEOM_W'(y_st);
    g.y_end = GEOM_W'(y_end);
    return g;
  endfunction

  function automatic geom_t geom_lookup(input logic [LUT_ID_W-1:0] id);
    geom_t g;
    case (id)
      ID_7084: g = mk_geom(800,  480, 1800, 1000, 187, 1763);
      ID_4384: g = mk_geom(800,  480, 1800, 1000, 187, 1763);
      ID_7016: g = mk_geom(1024, 600, 2200, 1000, 201, 1749);
      ID_1018: g = mk_geom(1280, 800, 2570,  980, 153, 1798);
      // ID_4342 and every unknown panel share the 480x272 entry
      default: g = mk_geom(480,  272, 1800, 1000, 228, 1723);
    endcase
    return g;
  endfunction

endpackage

// File: rtl/cmos_geom_ctrl_pix_area_mult.sv
// Sequential W x W shift-add multiplier.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load operands and perform the first partial product
//   a, b       : multiplicand / multiplier (sampled on start)
//   product    : a*b, valid while done is high and held afterwards
//   done       : one-cycle pulse, W cycles after the start edge
module pix_area_mult #(
  parameter int W = 13
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] product,
  output logic           done
);

  localparam int CW = $clog2(W + 1);

  logic [2*W-1:0] mcand_reg;
  logic [2*W-1:0] acc_reg;
  logic [W-1:0]   mplier_reg;
  logic [CW-1:0]  cnt_reg;
  logic           run_reg;
  logic           done_reg;

  // The start edge already consumes bit 0 of b, so W-1 further edges
  // finish the product and done is seen exactly W edges after start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_reg  <= '0;
      acc_reg    <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
      run_reg    <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        acc_reg    <= b[0] ? {{W{1'b0}}, a} : '0;
        mcand_reg  <= {{W{1'b0}}, a} << 1;
        mplier_reg <= b >> 1;
        cnt_reg    <= CW'(1);
        run_reg    <= (W > 1);
        done_reg   <= (W == 1);
      end else if (run_reg) begin
        if (mplier_reg[0]) begin
          acc_reg <= acc_reg + mcand_reg;
        end
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_reg >> 1;
        cnt_reg    <= cnt_reg + CW'(1);
        if (cnt_reg == CW'(W - 1)) begin
          run_reg  <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign product = acc_reg;
  assign done    = done_reg;

endmodule

// File: rtl/cmos_geom_ctrl.sv
// LCD-ID driven OV5640 geometry controller.
// Debounces {lcd_id, half_mode}, looks up the camera geometry, computes the
// DDR3 frame size, commits all outputs atomically and handshakes the result.
//   clk, rst_n      : clock, asynchronous active-low reset
//   lcd_id          : panel ID
//   half_mode       : 1 = camera output width/height halved
//   cfg_ack         : camera controller consumed the configuration
//   cmos_h/v_pixel  : active output size
//   total_h/v_pixel : HTS / VTS
//   y_addr_st/end   : sensor Y crop window
//   ddr3_addr_max   : h*v, zero-extended
//   cfg_req         : new configuration present, held until cfg_ack
//   cfg_valid       : configuration committed and acknowledged
//   busy            : controller not in DONE
// ADDR_W must be >= 2*PIX_W and STABLE_CYC >= 2.
module cmos_geom_ctrl
  import cmos_geom_pkg::*;
#(
  parameter int ID_W       = 16,
  parameter int PIX_W      = 13,
  parameter int ADDR_W     = 28,
  parameter int STABLE_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ID_W-1:0]   lcd_id,
  input  logic              half_mode,
  input  logic              cfg_ack,
  output logic [PIX_W-1:0]  cmos_h_pixel,
  output logic [PIX_W-1:0]  cmos_v_pixel,
  output logic [PIX_W-1:0]  total_h_pixel,
  output logic [PIX_W-1:0]  total_v_pixel,
  output logic [PIX_W-1:0]  y_addr_st,
  output logic [PIX_W-1:0]  y_addr_end,
  output logic [ADDR_W-1:0] ddr3_addr_max,
  output logic              cfg_req,
  output logic              cfg_valid,
  output logic              busy
);

  localparam int KEY_W = ID_W + 1;
  localparam int CNT_W = $clog2(STABLE_CYC + 1);

  logic [KEY_W-1:0] key_in;
  logic [KEY_W-1:0] key_reg;
  logic             key_chg;
  logic [CNT_W-1:0] cnt_reg;
  logic             clr_cnt;

  state_t state_reg, state_next;
  logic   start, commit;

  geom_t      lut;
  logic [PIX_W-1:0] look_h, look_v;

  logic [PIX_W-1:0] sh_h_reg, sh_v_reg, sh_hts_reg, sh_vts_reg, sh_yst_reg, sh_yend_reg;
  logic [PIX_W-1:0] h_reg, v_reg, hts_reg, vts_reg, yst_reg, yend_reg;
  logic [ADDR_W-1:0] ddr_reg;
  logic              req_reg, valid_reg, pend_reg;

  logic [2*PIX_W-1:0] product;
  logic               mult_done;

  assign key_in  = {lcd_id, half_mode};
  assign key_chg = (key_in != key_reg);

  // Leaving REQ with a pending change restarts debounce from zero.
  assign clr_cnt = (state_reg == ST_REQ) && cfg_ack && (pend_reg || key_chg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_reg <= '0;
      cnt_reg <= '0;
    end else begin
      key_reg <= key_in;
      if (key_chg || clr_cnt) begin
        cnt_reg <= '0;
      end else if (cnt_reg != CNT_W'(STABLE_CYC)) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  // key_reg equals the live key whenever LOOKUP proceeds (otherwise it aborts).
  assign lut    = geom_lookup(LUT_ID_W'(key_reg[KEY_W-1:1]));
  assign look_h = key_reg[0] ? (PIX_W'(lut.h) >> 1) : PIX_W'(lut.h);
  assign look_v = key_reg[0] ? (PIX_W'(lut.v) >> 1) : PIX_W'(lut.v);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_WAIT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      ST_WAIT: begin
        if (!key_chg && (cnt_reg == CNT_W'(STABLE_CYC - 1))) begin
          state_next = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (key_chg) begin
          state_next = ST_WAIT;
        end else begin
          start      = 1'b1;
          state_next = ST_MULT;
        end
      end
      ST_MULT: begin
        if (key_chg) begin
          state_next = ST_WAIT;
        end else if (mult_done) begin
          commit     = 1'b1;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (cfg_ack) begin
          state_next = (pend_reg || key_chg) ? ST_WAIT : ST_DONE;
        end
      end
      ST_DONE: begin
        if (key_chg) begin
          state_next = ST_WAIT;
        end
      end
      default: state_next = ST_WAIT;
    endcase
  end

  pix_area_mult #(.W(PIX_W)) u_mult (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (look_h),
    .b       (look_v),
    .product (product),
    .done    (mult_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_h_reg    <= '0;
      sh_v_reg    <= '0;
      sh_hts_reg  <= '0;
      sh_vts_reg  <= '0;
      sh_yst_reg  <= '0;
      sh_yend_reg <= '0;
    end else if (start) begin
      sh_h_reg    <= look_h;
      sh_v_reg    <= look_v;
      sh_hts_reg  <= PIX_W'(lut.hts);
      sh_vts_reg  <= PIX_W'(lut.vts);
      sh_yst_reg  <= PIX_W'(lut.y_st);
      sh_yend_reg <= PIX_W'(lut.y_end);
    end
  end

  // All seven geometry outputs move together on the commit edge only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_reg    <= '0;
      v_reg    <= '0;
      hts_reg  <= '0;
      vts_reg  <= '0;
      yst_reg  <= '0;
      yend_reg <= '0;
      ddr_reg  <= '0;
    end else if (commit) begin
      h_reg    <= sh_h_reg;
      v_reg    <= sh_v_reg;
      hts_reg  <= sh_hts_reg;
      vts_reg  <= sh_vts_reg;
      yst_reg  <= sh_yst_reg;
      yend_reg <= sh_yend_reg;
      ddr_reg  <= ADDR_W'(product);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_reg   <= 1'b0;
      pend_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      if (commit) begin
        req_reg <= 1'b1;
      end else if ((state_reg == ST_REQ) && cfg_ack) begin
        req_reg <= 1'b0;
      end
      if (state_reg == ST_REQ) begin
        if (cfg_ack) begin
          pend_reg <= 1'b0;
        end else if (key_chg) begin
          pend_reg <= 1'b1;
        end
      end
      // Registered so that valid rises one edge after the ack edge.
      valid_reg <= (state_reg == ST_DONE) && !key_chg;
    end
  end

  assign cmos_h_pixel  = h_reg;
  assign cmos_v_pixel  = v_reg;
  assign total_h_pixel = hts_reg;
  assign total_v_pixel = vts_reg;
  assign y_addr_st     = yst_reg;
  assign y_addr_end    = yend_reg;
  assign ddr3_addr_max = ddr_reg;
  assign cfg_req       = req_reg;
  assign cfg_valid     = valid_reg;
  assign busy          = (state_reg != ST_DONE);

endmodule
